inst_fetch: RTL and testbench

- Instruction-fetch stage directly upstream of the instruction ROM.
- Owns the program counter and drives the ROM chip-enable and byte address; the ROM returns the instruction combinationally in the same cycle.
- Captures each {pc, inst} pair into a small prefetch queue, so fetch keeps running while decode is stalled.
- Presents the queue head to decode with a valid/ready handshake and handles branch and exception redirects.

---
 rtl/inst_fetch_if.sv | 25 ++
 rtl/inst_fetch.sv | 125 ++++++++++++
 tb/tb_inst_fetch.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: ROM fetch port, decode handshake and redirect inputs.
// The master modport is the fetch stage; the slave modport is its environment.
interface inst_fetch_if;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        flush_i;
  logic [31:0] new_pc_i;

  modport master (
    output rom_ce, rom_addr, id_valid, id_pc, id_inst,
    input  rom_inst, id_ready, branch_flag_i, branch_target_i, flush_i, new_pc_i
  );

  modport slave (
    input  rom_ce, rom_addr, id_valid, id_pc, id_inst,
    output rom_inst, id_ready, branch_flag_i, branch_target_i, flush_i, new_pc_i
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the pc, fetches from ROM into a prefetch queue, hands the head to decode.
// Optional MIPS delay-slot retention on taken branches is enabled by defining INST_FETCH_DELAY_SLOT_EN.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic          clk,
  input  logic          rst,
  inst_fetch_if.master  bus
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] PTR_TWO  = AW'(2);
  localparam logic [31:0]   PC_STEP  = 32'd4;

  logic [31:0]   pc_r;
  logic [31:0]   pc_s;
  logic          ce_r;
  logic [31:0]   mem_pc_r   [DEPTH];
  logic [31:0]   mem_inst_r [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] rd_ptr_s;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] wr_ptr_s;
  logic [AW:0]   count_r;
  logic [AW:0]   count_s;
  logic          rom_ce_s;
  logic          id_valid_s;
  logic          pop_s;
  logic          br_s;
  logic          we_s;

  // Outputs are forced inactive while reset is asserted, even mid-stream.
  assign rom_ce_s     = ce_r & ~rst & (count_r != CNT_FULL);
  assign id_valid_s   = ~rst & (count_r != CNT_ZERO);
  assign pop_s        = id_valid_s & bus.id_ready;
  assign br_s         = pop_s & bus.branch_flag_i;

  assign bus.rom_ce   = rom_ce_s;
  assign bus.rom_addr = pc_r;
  assign bus.id_valid = id_valid_s;
  assign bus.id_pc    = id_valid_s ? mem_pc_r[rd_ptr_r]   : 32'h0000_0000;
  assign bus.id_inst  = id_valid_s ? mem_inst_r[rd_ptr_r] : 32'h0000_0000;

  // Next pc, pointers and occupancy; flush outranks branch, branch outranks streaming.
  always_comb begin
    pc_s     = pc_r;
    rd_ptr_s = rd_ptr_r;
    wr_ptr_s = wr_ptr_r;
    count_s  = count_r;
    we_s     = 1'b0;
    if (bus.flush_i) begin
      pc_s     = bus.new_pc_i;
      rd_ptr_s = PTR_ZERO;
      wr_ptr_s = PTR_ZERO;
      count_s  = CNT_ZERO;
    end else if (br_s) begin
      pc_s = bus.branch_target_i;
`ifdef INST_FETCH_DELAY_SLOT_EN
      if (count_r > CNT_ONE) begin
        // The entry behind the branch is the delay slot; everything after it is dropped.
        rd_ptr_s = rd_ptr_r + PTR_ONE;
        wr_ptr_s = rd_ptr_r + PTR_TWO;
        count_s  = CNT_ONE;
      end else begin
        // Queue drains with this pop, so the word being fetched now is the delay slot.
        we_s     = rom_ce_s;
        rd_ptr_s = rd_ptr_r + PTR_ONE;
        wr_ptr_s = rom_ce_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
        count_s  = rom_ce_s ? CNT_ONE : CNT_ZERO;
      end
`else
      rd_ptr_s = PTR_ZERO;
      wr_ptr_s = PTR_ZERO;
      count_s  = CNT_ZERO;
`endif
    end else begin
      we_s = rom_ce_s;
      if (rom_ce_s) begin
        wr_ptr_s = wr_ptr_r + PTR_ONE;
        pc_s     = pc_r + PC_STEP;
      end else begin
        wr_ptr_s = wr_ptr_r;
        pc_s     = pc_r;
      end
      if (pop_s) begin
        rd_ptr_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_s = rd_ptr_r;
      end
      count_s = count_r + (AW+1)'(rom_ce_s) - (AW+1)'(pop_s);
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r     <= RESET_PC;
      ce_r     <= 1'b0;
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      pc_r     <= pc_s;
      ce_r     <= 1'b1;
      rd_ptr_r <= rd_ptr_s;
      wr_ptr_r <= wr_ptr_s;
      count_r  <= count_s;
    end
  end

  // Queue storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_pc_r[wr_ptr_r]   <= pc_r;
      mem_inst_r[wr_ptr_r] <= bus.rom_inst;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a queue scoreboard predicts every fetch and decode output per cycle.
// A second instance with a high reset pc checks address wrap-around.
module tb_inst_fetch;

  localparam int          DEPTH   = 4;
  localparam logic [31:0] KEY     = 32'hA5A5_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_fetch_if bus ();
  inst_fetch_if wbus ();

  inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  inst_fetch #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (wbus.master)
  );

  // ROM model: instruction word is a fixed function of its address.
  assign bus.rom_inst         = bus.rom_addr ^ KEY;
  assign wbus.rom_inst        = wbus.rom_addr ^ KEY;
  assign wbus.id_ready        = 1'b1;
  assign wbus.branch_flag_i   = 1'b0;
  assign wbus.branch_target_i = 32'h0000_0000;
  assign wbus.flush_i         = 1'b0;
  assign wbus.new_pc_i        = 32'h0000_0000;

  logic [63:0] sb_q[$];
  logic [31:0] m_pc;
  logic        m_ce;
  int          since_rel;
  int          n_cmp;
  int          n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check outputs, advance the scoreboard.
  task automatic step(input logic r, input logic rdy, input logic br, input logic [31:0] tgt,
                      input logic fl, input logic [31:0] npc);
    logic        e_ce;
    logic        e_val;
    logic        pop;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [63:0] keep;
    rst                 = r;
    bus.id_ready        = rdy;
    bus.branch_flag_i   = br;
    bus.branch_target_i = tgt;
    bus.flush_i         = fl;
    bus.new_pc_i        = npc;
    #1;
    e_ce   = !r && m_ce && (sb_q.size() < DEPTH);
    e_val  = !r && (sb_q.size() != 0);
    e_pc   = e_val ? sb_q[0][63:32] : 32'h0000_0000;
    e_inst = e_val ? sb_q[0][31:0]  : 32'h0000_0000;
    chk("rom_ce",   {31'd0, bus.rom_ce},   {31'd0, e_ce});
    if (e_ce) chk("rom_addr", bus.rom_addr, m_pc);
    chk("id_valid", {31'd0, bus.id_valid}, {31'd0, e_val});
    chk("id_pc",    bus.id_pc,   e_pc);
    chk("id_inst",  bus.id_inst, e_inst);
    if (!r && since_rel >= 2 && since_rel <= 5) begin
      chk("wrap_valid", {31'd0, wbus.id_valid}, 32'd1);
      chk("wrap_pc",    wbus.id_pc,   WRAP_PC + 32'(4 * (since_rel - 2)));
      chk("wrap_inst",  wbus.id_inst, (WRAP_PC + 32'(4 * (since_rel - 2))) ^ KEY);
    end
    pop = e_val && rdy;
    if (r) begin
      sb_q.delete();
      m_pc      = 32'h0000_0000;
      m_ce      = 1'b0;
      since_rel = 0;
    end else begin
      since_rel++;
      if (fl) begin
        sb_q.delete();
        m_pc = npc;
      end else if (pop && br) begin
`ifdef INST_FETCH_DELAY_SLOT_EN
        void'(sb_q.pop_front());
        if (sb_q.size() != 0) begin
          keep = sb_q[0];
          sb_q.delete();
          sb_q.push_back(keep);
        end else if (e_ce) begin
          sb_q.push_back({m_pc, m_pc ^ KEY});
        end
`else
        sb_q.delete();
`endif
        m_pc = tgt;
      end else begin
        if (pop) void'(sb_q.pop_front());
        if (e_ce) begin
          sb_q.push_back({m_pc, m_pc ^ KEY});
          m_pc = m_pc + 32'd4;
        end
      end
      m_ce = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    n_cmp               = 0;
    n_err               = 0;
    since_rel           = 0;
    m_pc                = 32'h0000_0000;
    m_ce                = 1'b0;
    rst                 = 1'b1;
    bus.id_ready        = 1'b0;
    bus.branch_flag_i   = 1'b0;
    bus.branch_target_i = 32'h0000_0000;
    bus.flush_i         = 1'b0;
    bus.new_pc_i        = 32'h0000_0000;
    @(negedge clk);

    // Reset, then free streaming.
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (10) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

    // Mid-stream reset, then backpressure until full, then drain.
    repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (11) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (8) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

    // Branch popping 0x8 while 0xC and 0x10 sit behind it.
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (6) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
    repeat (6) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

    // Branch popping 0x8 while streaming, so nothing sits behind it.
    repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
    repeat (5) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

    // Branch flag without a pop is ignored.
    repeat (3) step(1'b0, 1'b0, 1'b1, 32'h0000_0300, 1'b0, 32'h0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

    // Flush in the same cycle as a branch pop, then flush while full.
    step(1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0180);
    repeat (5) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (6) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0040);
    repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

    // Random mix of readiness, branches, flushes and occasional resets.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 7) == 0,
           {$urandom(), 2'b00} & 32'h0000_FFFC,
           $urandom_range(0, 29) == 0,
           {$urandom(), 2'b00} & 32'h0000_FFFC);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
